state_machine_control: RTL and testbench

Top-level sequencer for the two-phase memory preparation flow: an init engine fills the working memory, then a shuffle engine permutes it. On `start`, the block launches each engine in turn and waits for each one to finish. It owns the single memory write port and routes the active engine's write enable, address and data to it. It signals `finish` when both phases are complete.

---
 rtl/sm_ctrl_pkg.sv | 40 ++++
 rtl/write_port_mux.sv | 59 +++++
 rtl/state_machine_control.sv | 98 +++++++++
 tb/tb_state_machine_control.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sm_ctrl_pkg
// Shared definitions for the two-phase memory preparation sequencer:
//   - state_t     : sequencer FSM states
//   - wp_sel_t    : write-port source select (none / init / shuffle)
//   - ADDR_W_DEF  : default memory address width
//   - DATA_W_DEF  : default memory data width
//   - sel_for_state() : maps an FSM state to the write-port owner
// ----------------------------------------------------------------------------
package sm_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_INIT = 3'd1,
    W_INIT = 3'd2,
    S_SHUF = 3'd3,
    W_SHUF = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_INIT = 2'd1,
    SEL_SHUF = 2'd2
  } wp_sel_t;

  // The engine that is being launched or waited on owns the memory port;
  // outside an active phase nobody does, so the port is parked at zero.
  function automatic wp_sel_t sel_for_state(input state_t st);
    case (st)
      S_INIT, W_INIT: sel_for_state = SEL_INIT;
      S_SHUF, W_SHUF: sel_for_state = SEL_SHUF;
      default:        sel_for_state = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/write_port_mux.sv
// ----------------------------------------------------------------------------
// write_port_mux
// Three-way combinational selection of the single memory write port.
// Ports:
//   sel                  : 2-bit owner select (0 none, 1 init, 2 shuffle)
//   write_enable_init    : init engine write enable
//   address_init         : init engine address
//   write_data_init      : init engine data
//   write_enable_shuffle : shuffle engine write enable
//   address_shuffle      : shuffle engine address
//   write_data_shuffle   : shuffle engine data
//   write_enable_out     : muxed write enable
//   address_out          : muxed address
//   write_data_out       : muxed data
// ----------------------------------------------------------------------------
module write_port_mux
  import sm_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        sel,
  input  logic              write_enable_init,
  input  logic [ADDR_W-1:0] address_init,
  input  logic [DATA_W-1:0] write_data_init,
  input  logic              write_enable_shuffle,
  input  logic [ADDR_W-1:0] address_shuffle,
  input  logic [DATA_W-1:0] write_data_shuffle,
  output logic              write_enable_out,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] write_data_out
);

  // The unused select encoding falls into the default branch, so a
  // corrupted select can never enable a write.
  always_comb begin
    write_enable_out = 1'b0;
    address_out      = '0;
    write_data_out   = '0;
    case (sel)
      SEL_INIT: begin
        write_enable_out = write_enable_init;
        address_out      = address_init;
        write_data_out   = write_data_init;
      end
      SEL_SHUF: begin
        write_enable_out = write_enable_shuffle;
        address_out      = address_shuffle;
        write_data_out   = write_data_shuffle;
      end
      default: begin
        write_enable_out = 1'b0;
        address_out      = '0;
        write_data_out   = '0;
      end
    endcase
  end

endmodule

// File: rtl/state_machine_control.sv
// ----------------------------------------------------------------------------
// state_machine_control
// Sequencer for the two-phase memory preparation flow: launches the init
// engine, waits for it, launches the shuffle engine, waits for it, then
// reports completion. Owns the single memory write port.
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   start          : level request to run init-then-shuffle
//   finish         : high while the sequence is complete
//   start_init     : one-cycle launch pulse to the init engine
//   finish_init    : init engine done (pulse or level)
//   start_shuffle  : one-cycle launch pulse to the shuffle engine
//   finish_shuffle : shuffle engine done (pulse or level)
//   write_enable_* / address_* / write_data_* : engine write ports in,
//                    muxed memory write port out
// ----------------------------------------------------------------------------
module state_machine_control
  import sm_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic              start_init,
  input  logic              finish_init,
  output logic              start_shuffle,
  input  logic              finish_shuffle,
  input  logic              write_enable_init,
  input  logic              write_enable_shuffle,
  output logic              write_enable_out,
  input  logic [ADDR_W-1:0] address_init,
  input  logic [ADDR_W-1:0] address_shuffle,
  output logic [ADDR_W-1:0] address_out,
  input  logic [DATA_W-1:0] write_data_init,
  input  logic [DATA_W-1:0] write_data_shuffle,
  output logic [DATA_W-1:0] write_data_out
);

  state_t     state;
  state_t     state_next;
  logic [1:0] wp_sel;

  // State register. Reset is asynchronous so an aborted run drops the
  // write port immediately; the engines share this reset net.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Done inputs are only looked at in their own wait state, so a done
  // level left over from a previous run cannot skip a launch.
  // DONE holds while start stays high: start is a level request and a
  // fresh run needs it to drop and rise again.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)          state_next = S_INIT;
      S_INIT:                      state_next = W_INIT;
      W_INIT:  if (finish_init)    state_next = S_SHUF;
      S_SHUF:                      state_next = W_SHUF;
      W_SHUF:  if (finish_shuffle) state_next = DONE;
      DONE:    if (!start)         state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Moore outputs decoded straight from the registered state.
  always_comb begin
    start_init    = (state == S_INIT);
    start_shuffle = (state == S_SHUF);
    finish        = (state == DONE);
    wp_sel        = sel_for_state(state);
  end

  write_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_write_port_mux (
    .sel                  (wp_sel),
    .write_enable_init    (write_enable_init),
    .address_init         (address_init),
    .write_data_init      (write_data_init),
    .write_enable_shuffle (write_enable_shuffle),
    .address_shuffle      (address_shuffle),
    .write_data_shuffle   (write_data_shuffle),
    .write_enable_out     (write_enable_out),
    .address_out          (address_out),
    .write_data_out       (write_data_out)
  );

endmodule

// File: tb/tb_state_machine_control.sv
// ----------------------------------------------------------------------------
// tb_state_machine_control
// Self-checking bench for state_machine_control: hand-written sequences for
// reset, full-sequence latency, no-retrigger, stale done and mid-run reset,
// plus a table of per-cycle vectors covering state decode and mux routing.
// ----------------------------------------------------------------------------
module tb_state_machine_control;

  logic       clk;
  logic       reset;
  logic       start;
  logic       finish;
  logic       start_init;
  logic       finish_init;
  logic       start_shuffle;
  logic       finish_shuffle;
  logic       write_enable_init;
  logic       write_enable_shuffle;
  logic       write_enable_out;
  logic [7:0] address_init;
  logic [7:0] address_shuffle;
  logic [7:0] address_out;
  logic [7:0] write_data_init;
  logic [7:0] write_data_shuffle;
  logic [7:0] write_data_out;

  int passed;
  int total;

  typedef struct {
    logic       start;
    logic       fi;
    logic       fs;
    logic       we_i;
    logic [7:0] a_i;
    logic [7:0] d_i;
    logic       we_s;
    logic [7:0] a_s;
    logic [7:0] d_s;
    logic       e_si;
    logic       e_ss;
    logic       e_fin;
    logic       e_we;
    logic [7:0] e_a;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs [10];

  state_machine_control #(
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .finish               (finish),
    .start_init           (start_init),
    .finish_init          (finish_init),
    .start_shuffle        (start_shuffle),
    .finish_shuffle       (finish_shuffle),
    .write_enable_init    (write_enable_init),
    .write_enable_shuffle (write_enable_shuffle),
    .write_enable_out     (write_enable_out),
    .address_init         (address_init),
    .address_shuffle      (address_shuffle),
    .address_out          (address_out),
    .write_data_init      (write_data_init),
    .write_data_shuffle   (write_data_shuffle),
    .write_data_out       (write_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic apply_stimulus(input vec_t v);
    start                = v.start;
    finish_init          = v.fi;
    finish_shuffle       = v.fs;
    write_enable_init    = v.we_i;
    address_init         = v.a_i;
    write_data_init      = v.d_i;
    write_enable_shuffle = v.we_s;
    address_shuffle      = v.a_s;
    write_data_shuffle   = v.d_s;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [7:0] a,
                            input logic [7:0] d);
    check_output({tag, "_we"},   write_enable_out, we);
    check_output({tag, "_addr"}, address_out, a);
    check_output({tag, "_data"}, write_data_out, d);
  endtask

  initial begin
    int si_count;
    int fin_low;
    passed = 0;
    total  = 0;

    // start, fi, fs, we_i, a_i, d_i, we_s, a_s, d_s, e_si, e_ss, e_fin, e_we, e_a, e_d
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'hC3, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'hC3};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'hAA};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'hAA};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

    // Reset held with start high: everything must stay quiet.
    reset                = 1'b0;
    start                = 1'b1;
    finish_init          = 1'b0;
    finish_shuffle       = 1'b0;
    write_enable_init    = 1'b1;
    address_init         = 8'h2A;
    write_data_init      = 8'h2A;
    write_enable_shuffle = 1'b1;
    address_shuffle      = 8'h55;
    write_data_shuffle   = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_start_init", start_init, 1'b0);
    check_output("rst_start_shuffle", start_shuffle, 1'b0);
    check_output("rst_finish", finish, 1'b0);
    check_port("rst_port", 1'b0, 8'h00, 8'h00);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("rel_si_before_edge", start_init, 1'b0);
    @(posedge clk); #1;
    check_output("rel_si_pulse", start_init, 1'b1);
    check_port("s_init_port", 1'b1, 8'h2A, 8'h2A);
    @(posedge clk); #1;
    check_output("rel_si_single", start_init, 1'b0);
    check_port("w_init_port", 1'b1, 8'h2A, 8'h2A);

    // Init engine answers 20 cycles after its launch.
    repeat (18) @(posedge clk);
    #1;
    check_output("w_init_no_ss", start_shuffle, 1'b0);
    @(negedge clk);
    finish_init = 1'b1;
    @(posedge clk); #1;
    check_output("ss_pulse", start_shuffle, 1'b1);
    check_port("s_shuf_port", 1'b1, 8'h55, 8'hAA);
    @(negedge clk);
    finish_init = 1'b0;
    @(posedge clk); #1;
    check_output("ss_single", start_shuffle, 1'b0);
    check_output("w_shuf_no_fin", finish, 1'b0);

    // Shuffle engine answers 30 cycles later.
    repeat (28) @(posedge clk);
    @(negedge clk);
    finish_shuffle = 1'b1;
    @(posedge clk); #1;
    check_output("fin_set", finish, 1'b1);
    check_port("done_port", 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    finish_shuffle = 1'b0;

    // Start held high in DONE: no rerun and finish stays up.
    si_count = 0;
    fin_low  = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (start_init) si_count++;
      if (!finish) fin_low++;
    end
    check_output("no_retrigger", si_count, 0);
    check_output("fin_held", fin_low, 0);

    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check_output("fin_clear", finish, 1'b0);

    // Per-cycle vector table: one clock edge between consecutive vectors.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_si", i), start_init, vecs[i].e_si);
      check_output($sformatf("vec%0d_ss", i), start_shuffle, vecs[i].e_ss);
      check_output($sformatf("vec%0d_fin", i), finish, vecs[i].e_fin);
      check_port($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_a, vecs[i].e_d);
    end

    // Stale done levels: minimum-length run, init phase never skipped.
    @(negedge clk);
    reset          = 1'b0;
    start          = 1'b0;
    finish_init    = 1'b1;
    finish_shuffle = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("stale_idle_ss", start_shuffle, 1'b0);
    check_output("stale_idle_fin", finish, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check_output("stale_e1_si", start_init, 1'b1);
    check_output("stale_e1_ss", start_shuffle, 1'b0);
    @(posedge clk); #1;
    check_output("stale_e2_ss", start_shuffle, 1'b0);
    check_output("stale_e2_fin", finish, 1'b0);
    @(posedge clk); #1;
    check_output("stale_e3_ss", start_shuffle, 1'b1);
    @(posedge clk); #1;
    check_output("stale_e4_fin", finish, 1'b0);
    @(posedge clk); #1;
    check_output("stale_e5_fin", finish, 1'b1);
    @(negedge clk);
    start          = 1'b0;
    finish_init    = 1'b0;
    finish_shuffle = 1'b0;
    @(posedge clk); #1;
    check_output("stale_back_idle", finish, 1'b0);

    // Reset in W_SHUF while the shuffle engine is writing.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    finish_init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    finish_init = 1'b0;
    start       = 1'b1;
    @(posedge clk); #1;
    check_port("midrst_pre", 1'b1, 8'h55, 8'hAA);
    #2;
    reset = 1'b0;
    #1;
    check_port("midrst_async", 1'b0, 8'h00, 8'h00);
    check_output("midrst_ss", start_shuffle, 1'b0);
    check_output("midrst_fin", finish, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("midrst_restart_si", start_init, 1'b1);
    check_port("midrst_restart_port", 1'b1, 8'h2A, 8'h2A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
